store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Write-coalescing-free store buffer between the core's load/store stage and data memory (256 x 8, asynchronous read, write on posedge clk when mem_write is high).
- Accepts one load or store request per cycle.
- Queues stores in a DEPTH-entry circular FIFO and drains them to memory in program order during cycles when no request is accepted.
- Serves loads by forwarding from the youngest matching buffered store, or by reading memory; the response is registered.

Parameters:
- DEPTH, 4, number of buffered stores; power of 2, minimum 2.
- AW, 8, address width; matches the data memory address.
- DW, 8, data width; matches the data memory word.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid and req_ready are both high.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  AW  request address.
- req_wdata  in  DW  store data.
- drain_all  in  1  stop accepting requests and drain the buffer.
- rsp_valid  out  1  load data valid; one cycle after the load is accepted.
- rsp_rdata  out  DW  load data.
- empty  out  1  buffer holds no stores.
- mem_addr  out  AW  drives data memory A.
- mem_wdata  out  DW  drives data memory WD.
- mem_write  out  1  drives data memory mem_write.
- mem_rdata  in  DW  data memory out (combinational on mem_addr).

Behaviour:
- Reset (reset==0 at posedge):
  - count, wr_ptr and rd_ptr go to 0; rsp_valid=0; rsp_rdata=0.
  - All entries are invalidated. Buffered stores are discarded, not drained.
  - Outputs after reset: empty=1, mem_write=0, mem_addr=0, mem_wdata=0.
- Storage: DEPTH entries {addr, data}. wr_ptr and rd_ptr wrap modulo DEPTH. count has width clog2(DEPTH)+1.
- req_ready:
  - 0 if drain_all is high.
  - Otherwise 0 if req_we==1 and count==DEPTH.
  - Otherwise 1. Loads are never blocked by a full buffer.
- Store accept: write {req_addr, req_wdata} at wr_ptr; wr_ptr+1; count+1 (unless a drain fires the same cycle).
- Load accept, forwarding hit:
  - Compare req_addr against all valid entries.
  - If any entry matches, rsp_rdata <= data of the youngest match (closest to wr_ptr-1). Memory is not read.
- Load accept, miss: mem_addr=req_addr and mem_write=0; rsp_rdata <= mem_rdata.
- Load response: rsp_valid <= 1 on the cycle after any accepted load; otherwise rsp_valid <= 0.
- Drain:
  - drain_fire = (count != 0) && !(req_valid && req_ready).
  - When drain_fire is high: mem_addr=head addr, mem_wdata=head data, mem_write=1; rd_ptr+1; count-1.
- Memory port when idle: if no load and no drain, mem_addr=0, mem_wdata=0, mem_write=0.
- Full buffer with a store pending: req_ready=0, so drain_fire=1. The next cycle has count=DEPTH-1 and the store is accepted. A full buffer never deadlocks.
- Duplicate addresses: multiple stores to the same addr keep separate entries. They drain oldest first; loads forward the youngest.
- Hazards: a drain and an accepted load never share a cycle, so there is no read/write hazard on the memory port.
- drain_all: the buffer drains one entry per cycle; empty rises when count reaches 0. Deasserting drain_all mid-drain resumes normal operation immediately.
- empty = (count==0), combinational from state.

Decomposition:
- Package sb_pkg: AW, DW defaults; typedef sb_entry_t {logic [AW-1:0] addr; logic [DW-1:0] data;}; ptr and count width constants.
- Sub-module sb_fwd_match: combinational youngest-match finder.
  - Inputs: entries, valid mask, wr_ptr, load addr.
  - Outputs: hit, data.

Test Plan:
- Reset with reset=0 for 2 cycles, then reset=1 -> empty=1, rsp_valid=0, mem_write=0, req_ready=1.
- Store 0x10<-0xAA, then load 0x10 in the next cycle -> rsp_valid=1 one cycle later with rsp_rdata=0xAA; mem_write stays 0 during both accepted cycles.
- Stores 0x20<-0x01, then 0x20<-0x02, then load 0x20 -> rsp_rdata=0x02. With the bus idle, drains write 0x01 then 0x02 to 0x20 on consecutive cycles; memory ends at 0x02.
- Five back-to-back stores with DEPTH=4 -> fifth sees req_ready=0 for one cycle. mem_write=1 with the first store's address on that cycle; the fifth store is accepted on the following cycle.
- Preload memory 0x30=0x5C, buffer empty, load 0x30 -> mem_addr=0x30, mem_write=0; next cycle rsp_rdata=0x5C.
- Three stores buffered, then assert drain_all -> req_ready=0; three mem_write pulses in FIFO order; empty=1 after the third. Reset asserted mid-drain -> remaining entries discarded, empty=1, mem_write=0.

Source files
------------

// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared widths, depth defaults and entry type for the store buffer
package sb_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 8;
    localparam int SB_DW    = 8;
    localparam int SB_PTR_W = $clog2(SB_DEPTH);
    localparam int SB_CNT_W = SB_PTR_W + 1;

    // One buffered store; the entry layout follows the default address/data widths
    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// rtl/sb_fwd_match.sv - combinational finder for the youngest buffered store matching a load address
module sb_fwd_match
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t              i_entries [DEPTH],
    input  logic [DEPTH-1:0]       i_valid,
    input  logic [PTR_W-1:0]       i_wr_ptr,
    input  logic [SB_AW-1:0]       i_addr,
    output logic                   o_hit,
    output logic [SB_DW-1:0]       o_data
);

    // Walk from the oldest slot (wr_ptr) to the youngest (wr_ptr-1); later matches override earlier ones
    always_comb begin
        logic [PTR_W-1:0] w_idx;
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            w_idx = i_wr_ptr - PTR_W'(k);
            if (i_valid[w_idx] && (i_entries[w_idx].addr == i_addr)) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store buffer with load forwarding in front of a 256x8 data memory
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic          drain_all,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          empty,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t        r_entries [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_rsp_valid;
    logic [DW-1:0]    r_rsp_rdata;

    logic             w_accept;
    logic             w_store;
    logic             w_load;
    logic             w_drain;
    logic             w_fwd_hit;
    logic [DW-1:0]    w_fwd_data;
    sb_entry_t        w_head;

    // Loads are never held off by a full buffer; only stores wait for a free slot
    assign req_ready = !drain_all && !(req_we && (r_count == CNT_W'(DEPTH)));
    assign w_accept  = req_valid && req_ready;
    assign w_store   = w_accept && req_we;
    assign w_load    = w_accept && !req_we;
    // Drains use the memory port only on cycles with no accepted request; held off during reset
    // so discarded entries never reach memory
    assign w_drain   = reset && (r_count != '0) && !w_accept;
    assign w_head    = r_entries[r_rd_ptr];
    assign empty     = (r_count == '0);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fwd_match (
        .i_entries (r_entries),
        .i_valid   (r_valid),
        .i_wr_ptr  (r_wr_ptr),
        .i_addr    (req_addr),
        .o_hit     (w_fwd_hit),
        .o_data    (w_fwd_data)
    );

    // Memory port: drain writes the head entry, a load reads the request address, otherwise idle zeros
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        if (w_drain) begin
            mem_addr  = w_head.addr;
            mem_wdata = w_head.data;
            mem_write = 1'b1;
        end else if (w_load) begin
            mem_addr  = req_addr;
        end
    end

    // FIFO pointers, occupancy, entry valid bits and the registered load response
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_load;
            if (w_load) begin
                r_rsp_rdata <= w_fwd_hit ? w_fwd_data : mem_rdata;
            end
            if (w_store) begin
                r_entries[r_wr_ptr] <= '{addr: req_addr, data: req_wdata};
                r_valid[r_wr_ptr]   <= 1'b1;
                r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
                r_count             <= r_count + CNT_W'(1);
            end else if (w_drain) begin
                r_valid[r_rd_ptr]   <= 1'b0;
                r_rd_ptr            <= r_rd_ptr + PTR_W'(1);
                r_count             <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer with a queue-based reference model
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       drain_all;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       empty;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_write;
    logic [7:0] mem_rdata;

    logic [7:0] tb_mem  [256];
    logic [7:0] ref_mem [256];
    logic [7:0] q_addr [$];
    logic [7:0] q_data [$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    store_buffer #(
        .DEPTH (DEPTH),
        .AW    (8),
        .DW    (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .drain_all (drain_all),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .empty     (empty),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    assign mem_rdata = tb_mem[mem_addr];

    always @(posedge clk) begin
        if (mem_write) tb_mem[mem_addr] <= mem_wdata;
    end

    task automatic set_in(input logic v, input logic we, input logic [7:0] a,
                          input logic [7:0] d, input logic da);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        drain_all = da;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        set_in(1'b1, 1'b1, 8'h07, 8'h77, 1'b0);
        reset = 1'b0;
        tick();
        set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++;
        if (rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 00", rsp_rdata); end
        n_checks++;
        if (mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
        n_checks++;
        if (mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_mem_bus: got addr %h wdata %h want 00 00", mem_addr, mem_wdata);
        end
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_forward;
        do_reset();
        tb_mem[8'h10] = 8'h33;
        set_in(1'b1, 1'b1, 8'h10, 8'hAA, 1'b0);
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || mem_write !== 1'b0) begin
            n_fail++; $display("FAIL fwd_store_cycle: got ready %b mem_write %b want 1 0", req_ready, mem_write);
        end
        tick();
        set_in(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || mem_write !== 1'b0) begin
            n_fail++; $display("FAIL fwd_load_cycle: got ready %b mem_write %b want 1 0", req_ready, mem_write);
        end
        tick();
        set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hAA) begin
            n_fail++; $display("FAIL fwd_rsp: got valid %b data %h want 1 aa", rsp_valid, rsp_rdata);
        end
        #1;
        n_checks++;
        if (mem_write !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 8'hAA) begin
            n_fail++; $display("FAIL fwd_drain: got we %b addr %h data %h want 1 10 aa", mem_write, mem_addr, mem_wdata);
        end
        tick();
        n_checks++;
        if (empty !== 1'b1 || tb_mem[8'h10] !== 8'hAA) begin
            n_fail++; $display("FAIL fwd_after_drain: got empty %b mem %h want 1 aa", empty, tb_mem[8'h10]);
        end
    endtask

    task automatic test_duplicate;
        do_reset();
        set_in(1'b1, 1'b1, 8'h20, 8'h01, 1'b0);
        tick();
        set_in(1'b1, 1'b1, 8'h20, 8'h02, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h02) begin
            n_fail++; $display("FAIL dup_rsp: got valid %b data %h want 1 02", rsp_valid, rsp_rdata);
        end
        #1;
        n_checks++;
        if (mem_write !== 1'b1 || mem_addr !== 8'h20 || mem_wdata !== 8'h01) begin
            n_fail++; $display("FAIL dup_drain0: got we %b addr %h data %h want 1 20 01", mem_write, mem_addr, mem_wdata);
        end
        tick();
        n_checks++;
        if (mem_write !== 1'b1 || mem_addr !== 8'h20 || mem_wdata !== 8'h02) begin
            n_fail++; $display("FAIL dup_drain1: got we %b addr %h data %h want 1 20 02", mem_write, mem_addr, mem_wdata);
        end
        tick();
        n_checks++;
        if (empty !== 1'b1 || tb_mem[8'h20] !== 8'h02) begin
            n_fail++; $display("FAIL dup_final: got empty %b mem %h want 1 02", empty, tb_mem[8'h20]);
        end
    endtask

    task automatic test_full;
        logic [7:0] d [5];
        do_reset();
        for (int i = 0; i < 5; i++) d[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b1, 8'h40 + 8'(i), d[i], 1'b0);
            #1;
            n_checks++;
            if (req_ready !== 1'b1) begin n_fail++; $display("FAIL full_fill%0d_ready: got %b want 1", i, req_ready); end
            tick();
        end
        set_in(1'b1, 1'b1, 8'h44, d[4], 1'b0);
        #1;
        n_checks++;
        if (req_ready !== 1'b0 || mem_write !== 1'b1 || mem_addr !== 8'h40) begin
            n_fail++; $display("FAIL full_stall: got ready %b we %b addr %h want 0 1 40", req_ready, mem_write, mem_addr);
        end
        tick();
        n_checks++;
        if (req_ready !== 1'b1 || mem_write !== 1'b0) begin
            n_fail++; $display("FAIL full_accept5: got ready %b we %b want 1 0", req_ready, mem_write);
        end
        tick();
        set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        #1;
        for (int i = 1; i < 5; i++) begin
            n_checks++;
            if (mem_write !== 1'b1 || mem_addr !== 8'h40 + 8'(i) || mem_wdata !== d[i]) begin
                n_fail++; $display("FAIL full_drain%0d: got we %b addr %h data %h want 1 %h %h",
                                   i, mem_write, mem_addr, mem_wdata, 8'h40 + 8'(i), d[i]);
            end
            tick();
        end
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL full_empty: got %b want 1", empty); end
    endtask

    task automatic test_mem_load;
        do_reset();
        tb_mem[8'h30] = 8'h5C;
        set_in(1'b1, 1'b0, 8'h30, 8'h00, 1'b0);
        #1;
        n_checks++;
        if (mem_addr !== 8'h30 || mem_write !== 1'b0) begin
            n_fail++; $display("FAIL memld_bus: got addr %h we %b want 30 0", mem_addr, mem_write);
        end
        tick();
        set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h5C) begin
            n_fail++; $display("FAIL memld_rsp: got valid %b data %h want 1 5c", rsp_valid, rsp_rdata);
        end
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL memld_rsp_clear: got %b want 0", rsp_valid); end
    endtask

    task automatic test_drain_all;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, 8'h50 + 8'(i), 8'hC0 + 8'(i), 1'b0);
            tick();
        end
        set_in(1'b1, 1'b1, 8'h58, 8'hEE, 1'b1);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (req_ready !== 1'b0 || mem_write !== 1'b1 || mem_addr !== 8'h50 + 8'(i) || mem_wdata !== 8'hC0 + 8'(i)) begin
                n_fail++; $display("FAIL dall_drain%0d: got ready %b we %b addr %h data %h", i, req_ready, mem_write, mem_addr, mem_wdata);
            end
            tick();
        end
        n_checks++;
        if (empty !== 1'b1 || mem_write !== 1'b0) begin
            n_fail++; $display("FAIL dall_done: got empty %b we %b want 1 0", empty, mem_write);
        end
        do_reset();
        tb_mem[8'h61] = 8'h11;
        tb_mem[8'h62] = 8'h22;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, 8'h60 + 8'(i), 8'hD0 + 8'(i), 1'b0);
            tick();
        end
        set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if (empty !== 1'b1 || mem_write !== 1'b0) begin
            n_fail++; $display("FAIL dall_reset: got empty %b we %b want 1 0", empty, mem_write);
        end
        n_checks++;
        if (tb_mem[8'h60] !== 8'hD0 || tb_mem[8'h61] !== 8'h11 || tb_mem[8'h62] !== 8'h22) begin
            n_fail++; $display("FAIL dall_discard: got mem %h %h %h want d0 11 22", tb_mem[8'h60], tb_mem[8'h61], tb_mem[8'h62]);
        end
    endtask

    task automatic test_random;
        logic       v, we, da, e_ready, acc, drn, ld, found;
        logic [7:0] a, d, e_maddr, e_mwd, e_rsp;
        int         guard;
        do_reset();
        q_addr.delete();
        q_data.delete();
        for (int i = 0; i < 256; i++) ref_mem[i] = tb_mem[i];
        for (int cyc = 0; cyc < 400; cyc++) begin
            v  = ($urandom_range(0, 9) < 7);
            we = 1'($urandom_range(0, 1));
            a  = 8'h80 + 8'($urandom_range(0, 7));
            d  = 8'($urandom);
            da = ($urandom_range(0, 9) == 0);
            set_in(v, we, a, d, da);
            #1;
            e_ready = !da && !(we && q_addr.size() == DEPTH);
            acc     = v && e_ready;
            drn     = (q_addr.size() != 0) && !acc;
            ld      = acc && !we;
            e_maddr = drn ? q_addr[0] : (ld ? a : 8'h00);
            e_mwd   = drn ? q_data[0] : 8'h00;
            e_rsp   = ref_mem[a];
            found   = 1'b0;
            for (int i = q_addr.size() - 1; i >= 0; i--) begin
                if (!found && q_addr[i] == a) begin
                    e_rsp = q_data[i];
                    found = 1'b1;
                end
            end
            n_checks++;
            if (req_ready !== e_ready || empty !== (q_addr.size() == 0)) begin
                n_fail++; $display("FAIL rand_ready cyc%0d: got ready %b empty %b want %b %b", cyc, req_ready, empty, e_ready, q_addr.size() == 0);
            end
            n_checks++;
            if (mem_write !== drn || mem_addr !== e_maddr || mem_wdata !== e_mwd) begin
                n_fail++; $display("FAIL rand_mem cyc%0d: got we %b addr %h data %h want %b %h %h", cyc, mem_write, mem_addr, mem_wdata, drn, e_maddr, e_mwd);
            end
            if (acc && we) begin
                q_addr.push_back(a);
                q_data.push_back(d);
            end
            if (drn) begin
                ref_mem[q_addr[0]] = q_data[0];
                void'(q_addr.pop_front());
                void'(q_data.pop_front());
            end
            tick();
            n_checks++;
            if (rsp_valid !== ld || (ld && rsp_rdata !== e_rsp)) begin
                n_fail++; $display("FAIL rand_rsp cyc%0d: got valid %b data %h want %b %h", cyc, rsp_valid, rsp_rdata, ld, e_rsp);
            end
        end
        set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        while (q_addr.size() != 0) begin
            ref_mem[q_addr[0]] = q_data[0];
            void'(q_addr.pop_front());
            void'(q_data.pop_front());
        end
        guard = 0;
        while (empty !== 1'b1 && guard < 2 * DEPTH) begin
            tick();
            guard++;
        end
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL rand_drain_timeout: got empty %b want 1", empty); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (tb_mem[8'h80 + i] !== ref_mem[8'h80 + i]) begin
                n_fail++; $display("FAIL rand_final_mem[%0h]: got %h want %h", 8'h80 + i, tb_mem[8'h80 + i], ref_mem[8'h80 + i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 8'($urandom);
        reset = 1'b0;
        set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        test_reset();
        test_forward();
        test_duplicate();
        test_full();
        test_mem_load();
        test_drain_all();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
